// File: rtl/adder_bcd_pkg.sv
// Shared BCD types and constants for the adder_bcd block.
package adder_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/adder_bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction and operand check.
module bcd_digit_add
  import adder_bcd_pkg::*;
(
  input  bcd_digit_t in0,
  input  bcd_digit_t in1,
  input  logic       cin,
  output logic       tens,
  output bcd_digit_t units,
  output logic       invalid
);

  logic [4:0] sum_bin;
  logic [4:0] sum_corr;

  always_comb begin
    sum_bin  = {1'b0, in0} + {1'b0, in1} + {4'b0000, cin};
    sum_corr = sum_bin;
    tens     = 1'b0;
    // Adding 6 to 10..19 lands on 16..25, so bit 4 is the decimal carry.
    if (sum_bin > {1'b0, BCD_MAX}) begin
      sum_corr = sum_bin + {1'b0, BCD_CORR};
      tens     = 1'b1;
    end
    units   = sum_corr[3:0];
    invalid = (in0 > BCD_MAX) || (in1 > BCD_MAX);
  end

endmodule

// File: rtl/adder_bcd.sv
// Registered BCD digit adder; define ADDER_BCD_CIN_EN to add a carry-in port.
module adder_bcd
  import adder_bcd_pkg::*;
#(
  parameter bcd_digit_t INVALID_DIGIT = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  bcd_digit_t in0,
  input  bcd_digit_t in1,
`ifdef ADDER_BCD_CIN_EN
  input  logic       cin,
`endif
  output bcd_digit_t out0,
  output bcd_digit_t out1,
  output logic       flag,
  output logic       out_valid
);

  logic       cin_w;
  logic       tens_w;
  bcd_digit_t units_w;
  logic       invalid_w;

  bcd_digit_t out0_q, out0_d;
  bcd_digit_t out1_q, out1_d;
  logic       flag_q, flag_d;
  logic       out_valid_q;

`ifdef ADDER_BCD_CIN_EN
  assign cin_w = cin;
`else
  assign cin_w = 1'b0;
`endif

  bcd_digit_add u_add (
    .in0     (in0),
    .in1     (in1),
    .cin     (cin_w),
    .tens    (tens_w),
    .units   (units_w),
    .invalid (invalid_w)
  );

  always_comb begin
    out0_d = out0_q;
    out1_d = out1_q;
    flag_d = flag_q;
    if (in_valid) begin
      flag_d = invalid_w;
      if (invalid_w) begin
        out0_d = INVALID_DIGIT;
        out1_d = INVALID_DIGIT;
      end else begin
        out0_d = units_w;
        out1_d = {3'b000, tens_w};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out0_q      <= '0;
      out1_q      <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      flag_q      <= flag_d;
      out_valid_q <= in_valid;
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign flag      = flag_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_bcd.sv
// Self-checking bench for adder_bcd against a decimal-arithmetic reference model.
module tb_adder_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in0, in1;
  logic       cin;
  logic [3:0] out0, out1;
  logic       flag, out_valid;

  int checks   = 0;
  int failures = 0;

  // Reference-model state (what the outputs should show after each edge).
  logic [3:0] m_out0, m_out1;
  logic       m_flag, m_valid;

  adder_bcd #(.INVALID_DIGIT(4'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
`ifdef ADDER_BCD_CIN_EN
    .cin       (cin),
`endif
    .out0      (out0),
    .out1      (out1),
    .flag      (flag),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [9:0] obs, exp;
    obs = {out_valid, flag, out1, out0};
    exp = {m_valid, m_flag, m_out1, m_out0};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed(v,f,o1,o0)=%b,%b,%0d,%0d expected=%b,%b,%0d,%0d",
             tag, obs[9], obs[8], obs[7:4], obs[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic model(input logic r, input logic v, input int a, input int b, input int c);
    int s;
    if (r) begin
      m_out0 = 0; m_out1 = 0; m_flag = 0; m_valid = 0;
    end else begin
      m_valid = v;
      if (v) begin
        if (a > 9 || b > 9) begin
          m_flag = 1; m_out0 = 4'd0; m_out1 = 4'd0;
        end else begin
          s = a + b + c;
          m_flag = 0; m_out1 = 4'(s / 10); m_out0 = 4'(s % 10);
        end
      end
    end
  endtask

  // Drive one cycle, advance past the edge, update model, compare.
  task automatic step(input string tag, input logic r, input logic v,
                      input int a1, input int a0, input int c);
    int ce;
`ifdef ADDER_BCD_CIN_EN
    ce = c;
`else
    ce = 0;
`endif
    rst = r; in_valid = v; in1 = 4'(a1); in0 = 4'(a0); cin = 1'(c);
    @(posedge clk);
    #1;
    model(r, v, a1, a0, ce);
    check(tag);
  endtask

  initial begin
    rst = 1; in_valid = 0; in0 = 0; in1 = 0; cin = 0;
    m_out0 = 0; m_out1 = 0; m_flag = 0; m_valid = 0;
    step("reset", 1, 0, 0, 0, 0);
    step("reset_drops_valid", 1, 1, 4, 5, 0);
    step("idle_after_reset", 0, 0, 0, 0, 0);

    step("4+5", 0, 1, 4, 5, 0);
    step("9+9", 0, 1, 9, 9, 0);
    step("7+5", 0, 1, 7, 5, 0);
    step("0+0", 0, 1, 0, 0, 0);
    step("5+5_boundary", 0, 1, 5, 5, 0);
    step("10+3_invalid", 0, 1, 10, 3, 0);
    step("0+15_invalid", 0, 1, 0, 15, 0);
    step("hold_after_invalid", 0, 0, 2, 2, 0);
    step("4+5_again", 0, 1, 4, 5, 0);
    step("hold_valid_result", 0, 0, 15, 15, 0);
    step("hold_twice", 0, 0, 1, 1, 0);
`ifdef ADDER_BCD_CIN_EN
    step("9+9+cin", 0, 1, 9, 9, 1);
    step("0+9+cin", 0, 1, 0, 9, 1);
    step("cin_ignored_invalid", 0, 1, 12, 9, 1);
`else
    step("cin_absent", 0, 1, 9, 9, 1);
`endif

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step($sformatf("sweep_%0d_%0d", a, b), 0, 1, a, b, (a + b) & 1);

    for (int i = 0; i < 300; i++)
      step($sformatf("rand_%0d", i), 0, 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)));

    step("pre_reset", 0, 1, 8, 7, 0);
    step("mid_reset", 1, 1, 9, 6, 0);
    step("post_reset_hold1", 0, 0, 9, 9, 0);
    step("post_reset_hold2", 0, 0, 3, 3, 0);
    step("post_reset_first", 0, 1, 3, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
